// File: rtl/sat_add_pkg.sv
// Shared types and constants for the saturating-add scheduler and its adder core.
package sat_add_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam int          DEF_BIT_WIDTH = 16;
  localparam int          CNT_W         = 4;
  localparam logic [15:0] SAT_MAX       = 16'h7FFF;
  localparam logic [15:0] SAT_MIN       = 16'h8000;

endpackage

// File: rtl/sat_add_core.sv
// Combinational signed saturating adder; clamps to the most positive/negative code on overflow.
module sat_add_core
  import sat_add_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic signed [BIT_WIDTH-1:0] x,
  input  logic signed [BIT_WIDTH-1:0] y,
  output logic signed [BIT_WIDTH-1:0] sum,
  output logic                        sat
);

  localparam logic [BIT_WIDTH-1:0] MAX_V = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] MIN_V = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  logic signed [BIT_WIDTH:0] w_sum_ext;

  // Returns {sat, value}; the extended sum overflowed when its top two bits disagree.
  function automatic logic [BIT_WIDTH:0] saturate(input logic signed [BIT_WIDTH:0] s);
    if (s[BIT_WIDTH] != s[BIT_WIDTH-1])
      return {1'b1, (s[BIT_WIDTH] ? MIN_V : MAX_V)};
    else
      return {1'b0, s[BIT_WIDTH-1:0]};
  endfunction

  assign w_sum_ext   = {x[BIT_WIDTH-1], x} + {y[BIT_WIDTH-1], y};
  assign {sat, sum}  = saturate(w_sum_ext);

endmodule

// File: rtl/sat_add_scheduler.sv
// Round-robin scheduler sharing one saturating adder between NUM_REQ valid/ready requesters.
module sat_add_scheduler
  import sat_add_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int ADD_LATENCY = 2,
  parameter int ID_W        = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_x,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_y,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [BIT_WIDTH-1:0]           resp_data,
  output logic                           resp_sat,
  output logic [ID_W-1:0]                resp_id,
  output logic                           busy
);

  state_t                        r_state, w_state_nxt;
  logic [ID_W-1:0]               r_rr_ptr, r_id, w_gnt_id;
  logic [CNT_W-1:0]              r_cnt;
  logic signed [BIT_WIDTH-1:0]   r_x, r_y, r_data, w_sum;
  logic                          r_sat, w_sat, w_gnt_found, w_accept, w_calc_done;

  // Scan from the round-robin pointer upward with wrap; first valid lane wins.
  always_comb begin : arb
    int idx;
    idx         = 0;
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_gnt_found && req_valid[idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_calc_done = 1'b0;
    case (r_state)
      IDLE: if (w_gnt_found) begin
        w_accept    = 1'b1;
        w_state_nxt = CALC;
      end
      CALC: if (r_cnt == '0) begin
        w_calc_done = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: if (resp_ready[r_id]) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand capture on accept; result registered when the latency counter expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_data   <= '0;
      r_sat    <= 1'b0;
    end else if (w_accept) begin
      r_x      <= req_x[int'(w_gnt_id)*BIT_WIDTH +: BIT_WIDTH];
      r_y      <= req_y[int'(w_gnt_id)*BIT_WIDTH +: BIT_WIDTH];
      r_id     <= w_gnt_id;
      r_rr_ptr <= (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
      r_cnt    <= CNT_W'(ADD_LATENCY-1);
    end else if (r_state == CALC) begin
      if (w_calc_done) begin
        r_data <= w_sum;
        r_sat  <= w_sat;
      end else begin
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end

  sat_add_core #(.BIT_WIDTH(BIT_WIDTH)) u_core (
    .x   (r_x),
    .y   (r_y),
    .sum (w_sum),
    .sat (w_sat)
  );

  assign req_ready  = (r_state == IDLE && w_gnt_found) ? (NUM_REQ'(1) << w_gnt_id) : '0;
  assign resp_valid = (r_state == RESP) ? (NUM_REQ'(1) << r_id) : '0;
  assign resp_data  = r_data;
  assign resp_sat   = r_sat;
  assign resp_id    = r_id;
  assign busy       = (r_state != IDLE);

endmodule
